// File: rtl/ff_bank_multimode.sv
// Bank of WIDTH flip-flops with runtime-selectable D/T/JK/SR personality and illegal-SR flagging.
// Optional saturating illegal-event counter enabled by defining FF_BANK_ERR_CNT_EN.
module ff_bank_multimode #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  parameter int unsigned           CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] err_nxt;

  assign mode_sel = mode_e'(mode);
  assign qb       = ~q;

  // b is never read in D/T modes, so an unknown b cannot reach q there
  always_comb begin
    q_nxt   = q;
    err_nxt = '0;
    if (en) begin
      unique case (mode_sel)
        MODE_D: q_nxt = a;
        MODE_T: q_nxt = q ^ a;
        MODE_JK: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({a[i], b[i]})
              2'b01:   q_nxt[i] = 1'b0;
              2'b10:   q_nxt[i] = 1'b1;
              2'b11:   q_nxt[i] = ~q[i];
              default: q_nxt[i] = q[i];
            endcase
          end
        end
        MODE_SR: begin
          for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({a[i], b[i]})
              2'b01:   q_nxt[i] = 1'b0;
              2'b10:   q_nxt[i] = 1'b1;
              2'b11:   err_nxt[i] = 1'b1;
              default: q_nxt[i] = q[i];
            endcase
          end
        end
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= RESET_VAL;
      err        <= '0;
      err_sticky <= 1'b0;
    end else begin
      q   <= q_nxt;
      err <= err_nxt;
      if (|err_nxt)
        err_sticky <= 1'b1;
      else if (clr_sticky)
        err_sticky <= 1'b0;
    end
  end

`ifdef FF_BANK_ERR_CNT_EN
  localparam int unsigned PC_W  = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = CNT_W + PC_W;

  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] cnt_max;
  logic [CNT_W-1:0] cnt_nxt;

  // Clear is applied before adding, so clear plus new events yields the new popcount
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      pop = pop + PC_W'(err_nxt[i]);
    cnt_max = SUM_W'({CNT_W{1'b1}});
    sum     = (clr_sticky ? '0 : SUM_W'(err_cnt)) + SUM_W'(pop);
    cnt_nxt = (sum > cnt_max) ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else
      err_cnt <= cnt_nxt;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ff_bank_multimode.sv
// Directed-vector bench for ff_bank_multimode; counter expectations follow FF_BANK_ERR_CNT_EN.
module tb_ff_bank_multimode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       clr_sticky = 1'b0;
  logic [7:0] q, qb, err;
  logic       err_sticky;
  logic [1:0] err_cnt;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  ff_bank_multimode #(
    .WIDTH     (8),
    .RESET_VAL (8'h00),
    .CNT_W     (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .a          (a),
    .b          (b),
    .clr_sticky (clr_sticky),
    .q          (q),
    .qb         (qb),
    .err        (err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_cnt(input logic [1:0] v);
`ifdef FF_BANK_ERR_CNT_EN
    return v;
`else
    return 2'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] va,
                       input logic [7:0] vb, input logic c);
    en = e; mode = m; a = va; b = vb; clr_sticky = c;
  endtask

  initial begin
    #12;
    check("rst_q", 32'(q), 32'h00);
    check("rst_qb", 32'(qb), 32'hFF);
    check("rst_err", 32'(err), 32'h00);
    check("rst_sticky", 32'(err_sticky), 32'h0);
    check("rst_cnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;

    // illegal SR from 00 so that sticky is set before the async reset
    drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b0); step();
    check("pre_q", 32'(q), 32'h00);
    check("pre_err", 32'(err), 32'h01);
    check("pre_sticky", 32'(err_sticky), 32'h1);
    drive(1'b1, 2'b00, 8'hA5, 8'hxx, 1'b0); step();
    check("d_xb_q", 32'(q), 32'hA5);
    check("d_err", 32'(err), 32'h00);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", 32'(q), 32'h00);
    check("arst_qb", 32'(qb), 32'hFF);
    check("arst_sticky", 32'(err_sticky), 32'h0);
    check("arst_cnt", 32'(err_cnt), 32'h0);
    step();
    check("arst_hold_q", 32'(q), 32'h00);
    rst_n = 1'b1;

    drive(1'b1, 2'b00, 8'h3C, 8'h00, 1'b0); step();
    check("d_q", 32'(q), 32'h3C);
    check("d_qb", 32'(qb), 32'hC3);
    drive(1'b0, 2'b00, 8'hFF, 8'h00, 1'b0); step();
    check("en0_q", 32'(q), 32'h3C);

    drive(1'b1, 2'b00, 8'h0F, 8'h00, 1'b0); step();
    drive(1'b1, 2'b01, 8'hFF, 8'hxx, 1'b0); step();
    check("t_q1", 32'(q), 32'hF0);
    step();
    check("t_q2", 32'(q), 32'h0F);

    // J=a,K=b: 7:6 toggle->1, 5:4 set, 3:2 reset, 1:0 hold
    drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0); step();
    drive(1'b1, 2'b10, 8'hF0, 8'hCC, 1'b0); step();
    check("jk_q", 32'(q), 32'hF0);
    drive(1'b1, 2'b10, 8'hC3, 8'hC0, 1'b0); step();
    check("jk_q2", 32'(q), 32'h33);

    drive(1'b1, 2'b00, 8'h55, 8'h00, 1'b0); step();
    drive(1'b1, 2'b11, 8'h03, 8'h01, 1'b0); step();
    check("sr_ill_q", 32'(q), 32'h57);
    check("sr_ill_err", 32'(err), 32'h01);
    check("sr_ill_sticky", 32'(err_sticky), 32'h1);
    check("sr_ill_cnt", 32'(err_cnt), 32'(exp_cnt(2'd1)));
    drive(1'b1, 2'b11, 8'h00, 8'h00, 1'b0); step();
    check("sr_hold_q", 32'(q), 32'h57);
    check("sr_hold_err", 32'(err), 32'h00);
    check("sr_hold_sticky", 32'(err_sticky), 32'h1);
    drive(1'b1, 2'b11, 8'h08, 8'h04, 1'b0); step();
    check("sr_setrst_q", 32'(q), 32'h5B);

    drive(1'b0, 2'b11, 8'hFF, 8'hFF, 1'b1); step();
    check("clr_sticky", 32'(err_sticky), 32'h0);
    check("clr_err", 32'(err), 32'h00);
    check("clr_q", 32'(q), 32'h5B);
    check("clr_cnt", 32'(err_cnt), 32'h0);

    drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b1); step();
    check("setclr_sticky", 32'(err_sticky), 32'h1);
    check("setclr_err", 32'(err), 32'h01);
    check("setclr_cnt", 32'(err_cnt), 32'(exp_cnt(2'd1)));
    drive(1'b1, 2'b11, 8'h80, 8'h80, 1'b0);
    step(); check("sat_cnt2", 32'(err_cnt), 32'(exp_cnt(2'd2)));
    step(); check("sat_cnt3", 32'(err_cnt), 32'(exp_cnt(2'd3)));
    step(); step();
    check("sat_cnt_hold", 32'(err_cnt), 32'(exp_cnt(2'd3)));
    check("sat_err", 32'(err), 32'h80);
    check("sat_q", 32'(q), 32'h5B);

    drive(1'b0, 2'b11, 8'hFF, 8'hFF, 1'b0); step();
    check("en0_sr_err", 32'(err), 32'h00);
    check("en0_cnt", 32'(err_cnt), 32'(exp_cnt(2'd3)));
    check("en0_sticky", 32'(err_sticky), 32'h1);

    drive(1'b1, 2'b00, 8'hAA, 8'hFF, 1'b0); step();
    check("modechg_q", 32'(q), 32'hAA);
    check("modechg_err", 32'(err), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
